snes_mem_responder: RTL and testbench

Memory-side responder for SNES and MCU accesses. It takes the translated address and hit/writable qualifiers from the address decoder, together with SNES bus-cycle pulses and MCU requests. It then runs timed read/write cycles on the 16-bit external ROM/SRAM. SNES cycles always take priority over MCU cycles.

---
 rtl/snes_mem_responder_if.sv | 48 ++++
 rtl/snes_mem_responder.sv | 199 +++++++++++++++++++
 tb/tb_snes_mem_responder.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snes_mem_responder_if.sv
// Bus bundle between the SNES/MCU request side, the responder and the external 16-bit
// ROM/SRAM. The responder uses the slave modport. The environment (request sources plus
// memory) uses the master modport.
//   Request side : snes_rd_start, snes_wr_end, rom_addr, rom_hit, is_writable, snes_data_in,
//                  snes_data_out, snes_rd_valid, mcu_rrq, mcu_wrq, mcu_addr, mcu_dout,
//                  mcu_din, mcu_rdy
//   Memory side  : mem_addr, mem_bhe_n, mem_ble_n, mem_oe_n, mem_we_n, mem_dout,
//                  mem_drive, mem_din
//   Status       : busy
interface snes_mem_responder_if;
  logic        snes_rd_start;
  logic        snes_wr_end;
  logic [23:0] rom_addr;
  logic        rom_hit;
  logic        is_writable;
  logic [7:0]  snes_data_in;
  logic [7:0]  snes_data_out;
  logic        snes_rd_valid;
  logic        mcu_rrq;
  logic        mcu_wrq;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_dout;
  logic [7:0]  mcu_din;
  logic        mcu_rdy;
  logic [22:0] mem_addr;
  logic        mem_bhe_n;
  logic        mem_ble_n;
  logic        mem_oe_n;
  logic        mem_we_n;
  logic [15:0] mem_dout;
  logic        mem_drive;
  logic [15:0] mem_din;
  logic        busy;

  modport slave (
    input  snes_rd_start, snes_wr_end, rom_addr, rom_hit, is_writable, snes_data_in,
    input  mcu_rrq, mcu_wrq, mcu_addr, mcu_dout, mem_din,
    output snes_data_out, snes_rd_valid, mcu_din, mcu_rdy,
    output mem_addr, mem_bhe_n, mem_ble_n, mem_oe_n, mem_we_n, mem_dout, mem_drive, busy
  );

  modport master (
    output snes_rd_start, snes_wr_end, rom_addr, rom_hit, is_writable, snes_data_in,
    output mcu_rrq, mcu_wrq, mcu_addr, mcu_dout, mem_din,
    input  snes_data_out, snes_rd_valid, mcu_din, mcu_rdy,
    input  mem_addr, mem_bhe_n, mem_ble_n, mem_oe_n, mem_we_n, mem_dout, mem_drive, busy
  );
endinterface

// File: rtl/snes_mem_responder.sv
// Memory-side responder: latches SNES and MCU requests and runs timed read/write cycles on
// the external 16-bit ROM/SRAM. SNES requests always win arbitration over MCU requests.
//   clk_i    : system clock, rising edge
//   rst_i    : synchronous active-high reset
//   bus_io   : request, memory and status signals (slave modport of snes_mem_responder_if)
//   AccessCycles : cycles OE_N/WE_N stay low per access (1..15)
module snes_mem_responder #(
  parameter int unsigned AccessCycles = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  snes_mem_responder_if.slave   bus_io
);

  typedef enum logic [2:0] {StIdle, StSnesRd, StSnesWr, StMcuRd, StMcuWr, StDone} state_e;

  localparam logic [3:0] CntLoad = 4'(AccessCycles - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        snes_rd_pend_q, snes_rd_pend_d;
  logic        snes_wr_pend_q, snes_wr_pend_d;
  logic [23:0] snes_addr_q, snes_addr_d;
  logic [7:0]  snes_data_q, snes_data_d;
  logic        mcu_pend_q, mcu_pend_d;
  logic        mcu_wr_q, mcu_wr_d;
  logic        mcu_busy_q, mcu_busy_d;
  logic [23:0] mcu_addr_q, mcu_addr_d;
  logic [7:0]  mcu_data_q, mcu_data_d;
  logic [23:0] cur_addr_q, cur_addr_d;
  logic [7:0]  cur_data_q, cur_data_d;
  logic        cur_snes_q, cur_snes_d;
  logic        cur_rd_q, cur_rd_d;
  logic [7:0]  snes_rdata_q, snes_rdata_d;
  logic [7:0]  mcu_rdata_q, mcu_rdata_d;

  logic        snes_wr_new, snes_rd_new, mcu_new;
  logic        snes_wr_avail, snes_rd_avail, mcu_avail;
  logic [23:0] snes_addr_sel, mcu_addr_sel;
  logic [7:0]  snes_data_sel, mcu_data_sel, rd_byte;
  logic        mcu_wr_sel;

  // Incoming pulses are folded into the arbitration view so an idle FSM dispatches them in
  // the same cycle. A qualified write displaces a simultaneous read.
  always_comb begin
    snes_wr_new   = bus_io.snes_wr_end & bus_io.rom_hit & bus_io.is_writable;
    snes_rd_new   = bus_io.snes_rd_start & bus_io.rom_hit & ~snes_wr_new;
    mcu_new       = (bus_io.mcu_rrq | bus_io.mcu_wrq) & ~mcu_pend_q;
    snes_wr_avail = snes_wr_new | (snes_wr_pend_q & ~snes_rd_new);
    snes_rd_avail = snes_rd_new | (snes_rd_pend_q & ~snes_wr_new);
    // The MCU slot stays full while its access runs, so mcu_busy_q masks it out.
    mcu_avail     = mcu_new | (mcu_pend_q & ~mcu_busy_q);
    snes_addr_sel = (snes_wr_new | snes_rd_new) ? bus_io.rom_addr : snes_addr_q;
    snes_data_sel = snes_wr_new ? bus_io.snes_data_in : snes_data_q;
    mcu_addr_sel  = mcu_new ? bus_io.mcu_addr : mcu_addr_q;
    mcu_data_sel  = mcu_new ? bus_io.mcu_dout : mcu_data_q;
    mcu_wr_sel    = mcu_new ? bus_io.mcu_wrq : mcu_wr_q;
    rd_byte       = cur_addr_q[0] ? bus_io.mem_din[15:8] : bus_io.mem_din[7:0];
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    snes_rd_pend_d = snes_rd_pend_q;
    snes_wr_pend_d = snes_wr_pend_q;
    snes_addr_d    = snes_addr_q;
    snes_data_d    = snes_data_q;
    mcu_pend_d     = mcu_pend_q;
    mcu_wr_d       = mcu_wr_q;
    mcu_busy_d     = mcu_busy_q;
    mcu_addr_d     = mcu_addr_q;
    mcu_data_d     = mcu_data_q;
    cur_addr_d     = cur_addr_q;
    cur_data_d     = cur_data_q;
    cur_snes_d     = cur_snes_q;
    cur_rd_d       = cur_rd_q;
    snes_rdata_d   = snes_rdata_q;
    mcu_rdata_d    = mcu_rdata_q;

    if (snes_wr_new) begin
      snes_wr_pend_d = 1'b1;
      snes_rd_pend_d = 1'b0;
      snes_addr_d    = bus_io.rom_addr;
      snes_data_d    = bus_io.snes_data_in;
    end else if (snes_rd_new) begin
      snes_rd_pend_d = 1'b1;
      snes_wr_pend_d = 1'b0;
      snes_addr_d    = bus_io.rom_addr;
    end
    if (mcu_new) begin
      mcu_pend_d = 1'b1;
      mcu_wr_d   = bus_io.mcu_wrq;
      mcu_addr_d = bus_io.mcu_addr;
      mcu_data_d = bus_io.mcu_dout;
    end

    unique case (state_q)
      StSnesRd, StSnesWr, StMcuRd, StMcuWr: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          if (state_q == StSnesRd) snes_rdata_d = rd_byte;
          if (state_q == StMcuRd)  mcu_rdata_d  = rd_byte;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StIdle, StDone: begin
        if (state_q == StDone && !cur_snes_q) begin
          mcu_pend_d = 1'b0;
          mcu_busy_d = 1'b0;
        end
        if (snes_wr_avail || snes_rd_avail) begin
          // SNES pending state is handed to cur_* at dispatch, so a new pulse during the
          // access is held for the next arbitration.
          state_d        = snes_wr_avail ? StSnesWr : StSnesRd;
          snes_rd_pend_d = 1'b0;
          snes_wr_pend_d = 1'b0;
          cur_addr_d     = snes_addr_sel;
          cur_data_d     = snes_data_sel;
          cur_snes_d     = 1'b1;
          cur_rd_d       = ~snes_wr_avail;
          cnt_d          = CntLoad;
        end else if (mcu_avail) begin
          state_d    = mcu_wr_sel ? StMcuWr : StMcuRd;
          mcu_busy_d = 1'b1;
          cur_addr_d = mcu_addr_sel;
          cur_data_d = mcu_data_sel;
          cur_snes_d = 1'b0;
          cur_rd_d   = ~mcu_wr_sel;
          cnt_d      = CntLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      cnt_q          <= 4'd0;
      snes_rd_pend_q <= 1'b0;
      snes_wr_pend_q <= 1'b0;
      snes_addr_q    <= 24'd0;
      snes_data_q    <= 8'd0;
      mcu_pend_q     <= 1'b0;
      mcu_wr_q       <= 1'b0;
      mcu_busy_q     <= 1'b0;
      mcu_addr_q     <= 24'd0;
      mcu_data_q     <= 8'd0;
      cur_addr_q     <= 24'd0;
      cur_data_q     <= 8'd0;
      cur_snes_q     <= 1'b0;
      cur_rd_q       <= 1'b0;
      snes_rdata_q   <= 8'd0;
      mcu_rdata_q    <= 8'd0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      snes_rd_pend_q <= snes_rd_pend_d;
      snes_wr_pend_q <= snes_wr_pend_d;
      snes_addr_q    <= snes_addr_d;
      snes_data_q    <= snes_data_d;
      mcu_pend_q     <= mcu_pend_d;
      mcu_wr_q       <= mcu_wr_d;
      mcu_busy_q     <= mcu_busy_d;
      mcu_addr_q     <= mcu_addr_d;
      mcu_data_q     <= mcu_data_d;
      cur_addr_q     <= cur_addr_d;
      cur_data_q     <= cur_data_d;
      cur_snes_q     <= cur_snes_d;
      cur_rd_q       <= cur_rd_d;
      snes_rdata_q   <= snes_rdata_d;
      mcu_rdata_q    <= mcu_rdata_d;
    end
  end

  logic rd_state, wr_state, done_state;

  always_comb begin
    rd_state             = (state_q == StSnesRd) || (state_q == StMcuRd);
    wr_state             = (state_q == StSnesWr) || (state_q == StMcuWr);
    done_state           = (state_q == StDone);
    bus_io.mem_oe_n      = ~rd_state;
    bus_io.mem_we_n      = ~wr_state;
    bus_io.mem_drive     = wr_state;
    bus_io.mem_bhe_n     = ~((rd_state | wr_state) & cur_addr_q[0]);
    bus_io.mem_ble_n     = ~((rd_state | wr_state) & ~cur_addr_q[0]);
    bus_io.mem_addr      = cur_addr_q[23:1];
    bus_io.mem_dout      = {cur_data_q, cur_data_q};
    bus_io.busy          = (state_q != StIdle);
    bus_io.snes_rd_valid = done_state & cur_snes_q & cur_rd_q;
    bus_io.mcu_rdy       = done_state & ~cur_snes_q;
    bus_io.snes_data_out = snes_rdata_q;
    bus_io.mcu_din       = mcu_rdata_q;
  end

endmodule

// File: tb/tb_snes_mem_responder.sv
module tb_snes_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  snes_mem_responder_if bus();

  snes_mem_responder #(.AccessCycles(3)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  // Simple external SRAM: 256 words, aliased on the low word-address bits.
  logic [15:0] dev_mem [256];
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = 8'd0;
  logic [15:0] ld_val = 16'd0;

  always @(posedge clk) begin
    if (ld_en) begin
      dev_mem[ld_idx] <= ld_val;
    end else if (!bus.mem_we_n) begin
      if (!bus.mem_ble_n) dev_mem[bus.mem_addr[7:0]][7:0]  <= bus.mem_dout[7:0];
      if (!bus.mem_bhe_n) dev_mem[bus.mem_addr[7:0]][15:8] <= bus.mem_dout[15:8];
    end
  end

  // Data only appears while the responder enables the outputs.
  always_comb bus.mem_din = !bus.mem_oe_n ? dev_mem[bus.mem_addr[7:0]] : 16'hDEAD;

  // Reference model: byte-addressed memory image, aliased the same way as the SRAM.
  logic [7:0] ref_mem [512];
  function automatic logic [7:0] ref_rd(input logic [23:0] a);
    return ref_mem[a[8:0]];
  endfunction

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    bus.snes_rd_start = 1'b0;
    bus.snes_wr_end   = 1'b0;
    bus.mcu_rrq       = 1'b0;
    bus.mcu_wrq       = 1'b0;
  endtask

  // Observation window: cycle i counts from the cycle the pending pulses are sampled.
  int         rdy_cnt, rdy_first, val_cnt, val_first, overlap;
  int         starts[$];
  logic [7:0] rdy_din, val_dout;

  task automatic mon(input int n);
    logic prev_low, low;
    rdy_cnt = 0; rdy_first = -1; val_cnt = 0; val_first = -1; overlap = 0;
    starts.delete();
    prev_low = !bus.mem_oe_n || !bus.mem_we_n;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) clear_pulses();
      low = !bus.mem_oe_n || !bus.mem_we_n;
      if (low && !prev_low) starts.push_back(i);
      prev_low = low;
      if (bus.mcu_rdy) begin
        rdy_cnt++;
        if (rdy_first < 0) rdy_first = i;
        rdy_din = bus.mcu_din;
      end
      if (bus.snes_rd_valid) begin
        val_cnt++;
        if (val_first < 0) val_first = i;
        val_dout = bus.snes_data_out;
      end
      if (bus.mem_drive && !bus.mem_oe_n) overlap++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a, b, c;
    logic [7:0]  d, exp_b, last_snes;
    logic [15:0] w;
    int          op;
    logic        hit, wrb, q;

    clear_pulses();
    bus.rom_addr = 24'd0; bus.rom_hit = 1'b0; bus.is_writable = 1'b0;
    bus.snes_data_in = 8'd0; bus.mcu_addr = 24'd0; bus.mcu_dout = 8'd0;

    // Fill SRAM and reference image while in reset.
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      ld_en = 1'b1; ld_idx = 8'(i); ld_val = w;
      ref_mem[2*i] = w[7:0]; ref_mem[2*i+1] = w[15:8];
      tick();
    end
    ld_idx = 8'h2B; ld_val = 16'hAB12;
    ref_mem[9'h056] = 8'h12; ref_mem[9'h057] = 8'hAB;
    tick();
    ld_en = 1'b0;
    tick();

    chk("rst_oe_n", 32'(bus.mem_oe_n), 1);
    chk("rst_we_n", 32'(bus.mem_we_n), 1);
    chk("rst_bhe_n", 32'(bus.mem_bhe_n), 1);
    chk("rst_ble_n", 32'(bus.mem_ble_n), 1);
    chk("rst_drive", 32'(bus.mem_drive), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_valid", 32'(bus.snes_rd_valid), 0);
    chk("rst_rdy", 32'(bus.mcu_rdy), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_dout", 32'(bus.mem_dout), 0);
    chk("rst_sdo", 32'(bus.snes_data_out), 0);
    chk("rst_mdin", 32'(bus.mcu_din), 0);
    rst = 1'b0;
    tick();

    // SNES read at 0x123457, high byte of word 0x091A2B.
    bus.rom_addr = 24'h123457; bus.rom_hit = 1'b1; bus.snes_rd_start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      clear_pulses();
      if (i <= 3) begin
        chk("rd1_oe_n", 32'(bus.mem_oe_n), 0);
        chk("rd1_addr", 32'(bus.mem_addr), 32'h091A2B);
        chk("rd1_bhe_n", 32'(bus.mem_bhe_n), 0);
        chk("rd1_ble_n", 32'(bus.mem_ble_n), 1);
        chk("rd1_valid_early", 32'(bus.snes_rd_valid), 0);
      end else if (i == 4) begin
        chk("rd1_oe_n_done", 32'(bus.mem_oe_n), 1);
        chk("rd1_valid", 32'(bus.snes_rd_valid), 1);
        chk("rd1_data", 32'(bus.snes_data_out), 32'hAB);
      end else begin
        chk("rd1_valid_after", 32'(bus.snes_rd_valid), 0);
        chk("rd1_busy_after", 32'(bus.busy), 0);
      end
    end
    last_snes = 8'hAB;

    // SNES write 0x5C to 0xE00000, writable.
    bus.rom_addr = 24'hE00000; bus.is_writable = 1'b1; bus.snes_data_in = 8'h5C;
    bus.snes_wr_end = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      clear_pulses();
      if (i <= 3) begin
        chk("wr1_we_n", 32'(bus.mem_we_n), 0);
        chk("wr1_drive", 32'(bus.mem_drive), 1);
        chk("wr1_oe_n", 32'(bus.mem_oe_n), 1);
        chk("wr1_dout", 32'(bus.mem_dout), 32'h5C5C);
        chk("wr1_ble_n", 32'(bus.mem_ble_n), 0);
        chk("wr1_bhe_n", 32'(bus.mem_bhe_n), 1);
      end else begin
        chk("wr1_we_n_done", 32'(bus.mem_we_n), 1);
        chk("wr1_busy_done", 32'(bus.busy), 1);
      end
    end
    ref_mem[9'h000] = 8'h5C;
    tick();

    // Same write, not writable: must not touch memory.
    bus.is_writable = 1'b0; bus.snes_data_in = 8'hA7; bus.snes_wr_end = 1'b1;
    mon(6);
    chk("wr2_starts", 32'(starts.size()), 0);
    chk("wr2_busy", 32'(bus.busy), 0);
    bus.snes_rd_start = 1'b1;
    mon(6);
    chk("wr2_readback_cnt", 32'(val_cnt), 1);
    chk("wr2_readback", 32'(val_dout), 32'h5C);
    last_snes = 8'h5C;

    // MCU read in flight when an SNES read arrives.
    a = 24'($urandom); b = 24'($urandom);
    bus.mcu_addr = a; bus.mcu_rrq = 1'b1;
    tick();
    clear_pulses();
    bus.rom_addr = b; bus.snes_rd_start = 1'b1;
    mon(12);
    chk("pri_rdy_cycle", 32'(rdy_first), 3);
    chk("pri_rdy_cnt", 32'(rdy_cnt), 1);
    chk("pri_mcu_data", 32'(rdy_din), 32'(ref_rd(a)));
    chk("pri_starts", 32'(starts.size()), 1);
    if (starts.size() > 0) chk("pri_snes_start", 32'(starts[0]), 4);
    chk("pri_valid_cycle", 32'(val_first), 7);
    chk("pri_valid_bound", 32'(val_first > 0 && val_first <= 2*3+3), 1);
    chk("pri_snes_data", 32'(val_dout), 32'(ref_rd(b)));
    last_snes = ref_rd(b);

    // Simultaneous SNES read and MCU write in IDLE.
    b = 24'($urandom); c = 24'($urandom); d = 8'($urandom);
    exp_b = ref_rd(b);
    bus.rom_addr = b; bus.snes_rd_start = 1'b1;
    bus.mcu_addr = c; bus.mcu_dout = d; bus.mcu_wrq = 1'b1;
    mon(12);
    chk("sim_starts", 32'(starts.size()), 2);
    if (starts.size() > 1) begin
      chk("sim_start0", 32'(starts[0]), 1);
      chk("sim_start1", 32'(starts[1]), 5);
    end
    chk("sim_valid_cycle", 32'(val_first), 4);
    chk("sim_snes_data", 32'(val_dout), 32'(exp_b));
    chk("sim_rdy_cycle", 32'(rdy_first), 8);
    chk("sim_rdy_cnt", 32'(rdy_cnt), 1);
    chk("sim_overlap", 32'(overlap), 0);
    ref_mem[c[8:0]] = d;
    last_snes = exp_b;

    // Reset on the second strobe cycle of an MCU write.
    c = 24'($urandom); d = 8'($urandom);
    bus.mcu_addr = c; bus.mcu_dout = d; bus.mcu_wrq = 1'b1;
    tick();
    clear_pulses();
    chk("rstw_we_first", 32'(bus.mem_we_n), 0);
    tick();
    chk("rstw_we_second", 32'(bus.mem_we_n), 0);
    rst = 1'b1;
    tick();
    chk("rstw_we_n", 32'(bus.mem_we_n), 1);
    chk("rstw_drive", 32'(bus.mem_drive), 0);
    chk("rstw_busy", 32'(bus.busy), 0);
    chk("rstw_rdy", 32'(bus.mcu_rdy), 0);
    rst = 1'b0;
    mon(6);
    chk("rstw_rdy_after", 32'(rdy_cnt), 0);
    chk("rstw_starts_after", 32'(starts.size()), 0);
    ref_mem[c[8:0]] = d;
    last_snes = 8'h00;

    // Second MCU_RRQ before MCU_RDY is dropped.
    a = 24'($urandom); b = 24'($urandom);
    bus.mcu_addr = a; bus.mcu_rrq = 1'b1;
    tick();
    clear_pulses();
    tick();
    bus.mcu_addr = b; bus.mcu_rrq = 1'b1;
    mon(10);
    chk("dup_rdy_cnt", 32'(rdy_cnt), 1);
    chk("dup_rdy_cycle", 32'(rdy_first), 2);
    chk("dup_starts", 32'(starts.size()), 0);
    chk("dup_data", 32'(rdy_din), 32'(ref_rd(a)));

    // Randomized single transactions against the reference image.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      a = 24'($urandom); d = 8'($urandom);
      hit = ($urandom_range(0, 3) != 0);
      wrb = ($urandom_range(0, 3) != 0);
      bus.rom_hit = hit; bus.is_writable = wrb;
      case (op)
        0: begin bus.rom_addr = a; bus.snes_rd_start = 1'b1; end
        1: begin bus.rom_addr = a; bus.snes_data_in = d; bus.snes_wr_end = 1'b1; end
        2: begin bus.mcu_addr = a; bus.mcu_rrq = 1'b1; end
        default: begin bus.mcu_addr = a; bus.mcu_dout = d; bus.mcu_wrq = 1'b1; end
      endcase
      q = (op == 0) ? hit : (op == 1) ? (hit && wrb) : 1'b1;
      mon(7);
      chk("rnd_starts", 32'(starts.size()), 32'(q));
      chk("rnd_overlap", 32'(overlap), 0);
      if (op == 0) begin
        chk("rnd_srd_cnt", 32'(val_cnt), 32'(q));
        if (q) begin
          chk("rnd_srd_cycle", 32'(val_first), 4);
          chk("rnd_srd_data", 32'(val_dout), 32'(ref_rd(a)));
          last_snes = ref_rd(a);
        end
        chk("rnd_srd_hold", 32'(bus.snes_data_out), 32'(last_snes));
      end else if (op == 1) begin
        chk("rnd_swr_valid", 32'(val_cnt), 0);
        if (q) ref_mem[a[8:0]] = d;
      end else begin
        chk("rnd_mcu_cnt", 32'(rdy_cnt), 1);
        chk("rnd_mcu_cycle", 32'(rdy_first), 4);
        if (op == 2) chk("rnd_mrd_data", 32'(rdy_din), 32'(ref_rd(a)));
        else ref_mem[a[8:0]] = d;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
